sim_trap_monitor: RTL and testbench

//  Synthesizable end-of-test monitor for the NPC simulation top. Observes up to NCOMMIT retire lanes and

---
 rtl/sim_trap_monitor_if.sv | 24 ++
 rtl/sim_trap_monitor.sv | 147 ++++++++++++++
 tb/tb_sim_trap_monitor.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sim_trap_monitor_if.sv
// rtl/sim_trap_monitor_if.sv - retire-lane bundle observed by the end-of-test monitor
interface sim_trap_monitor_if #(
    parameter int XLEN    = 32,
    parameter int NCOMMIT = 1
);
    logic [NCOMMIT-1:0]      commit_valid;
    logic [NCOMMIT*XLEN-1:0] commit_pc;
    logic [NCOMMIT*XLEN-1:0] commit_instr;
    logic [XLEN-1:0]         a0_value;

    modport master (
        output commit_valid,
        output commit_pc,
        output commit_instr,
        output a0_value
    );

    modport slave (
        input commit_valid,
        input commit_pc,
        input commit_instr,
        input a0_value
    );
endinterface

// File: rtl/sim_trap_monitor.sv
// rtl/sim_trap_monitor.sv - trap/timeout/stall end-of-test monitor with counters and PC trace ring
module sim_trap_monitor #(
    parameter int              XLEN        = 32,
    parameter int              NCOMMIT     = 1,
    parameter int              MAX_CYCLES  = 1000000,
    parameter int              STALL_LIMIT = 1024,
    parameter int              TRACE_DEPTH = 16,
    parameter logic [XLEN-1:0] TRAP_INSN   = 32'h00100073,
    parameter int              CNT_W       = 64,
    localparam int             IW          = $clog2(TRACE_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    sim_trap_monitor_if.slave   cif,
    input  logic [IW-1:0]       trace_rd_idx_i,
    output logic [XLEN-1:0]     trace_rd_pc_o,
    output logic [IW:0]         trace_count_o,
    output logic                done_o,
    output logic [2:0]          status_o,
    output logic [CNT_W-1:0]    cycle_count_o,
    output logic [CNT_W-1:0]    instret_o,
    output logic [XLEN-1:0]     trap_pc_o
);
    localparam int TCW = IW + 1;
    localparam int CW  = $clog2(NCOMMIT + 1);
    localparam int SW  = $clog2(STALL_LIMIT + 1);

    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_GOOD    = 3'd1;
    localparam logic [2:0] ST_BAD     = 3'd2;
    localparam logic [2:0] ST_UNKNOWN = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;
    localparam logic [2:0] ST_STALL   = 3'd5;

    typedef enum logic {S_RUN, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        status_q, status_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [XLEN-1:0]   trap_pc_q, trap_pc_d;
    logic [IW-1:0]     wptr_q, wptr_d;
    logic [TCW-1:0]    tcount_q, tcount_d;
    logic [SW-1:0]     stall_q, stall_d;
    logic [XLEN-1:0]   trace_q [TRACE_DEPTH];
    logic [XLEN-1:0]   trace_d [TRACE_DEPTH];

    logic              trap_hit;
    logic              any_valid;
    logic [CW-1:0]     n_cnt;
    logic [XLEN-1:0]   lane_pc;
    logic [IW-1:0]     rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RUN;
            status_q  <= ST_RUN;
            cycle_q   <= '0;
            instret_q <= '0;
            trap_pc_q <= '0;
            wptr_q    <= '0;
            tcount_q  <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            trap_pc_q <= trap_pc_d;
            wptr_q    <= wptr_d;
            tcount_q  <= tcount_d;
            stall_q   <= stall_d;
        end
    end

    // Trace contents are don't-care after reset, so the ring carries no reset.
    always_ff @(posedge clk) begin
        trace_q <= trace_d;
    end

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;
        trap_pc_d = trap_pc_q;
        wptr_d    = wptr_q;
        tcount_d  = tcount_q;
        stall_d   = stall_q;
        trace_d   = trace_q;
        trap_hit  = 1'b0;
        any_valid = |cif.commit_valid;
        n_cnt     = '0;
        lane_pc   = '0;

        if (state_q == S_RUN) begin
            cycle_d = cycle_q + CNT_W'(1);
            // Lanes after the first valid trap are younger than the trap and never retire.
            for (int i = 0; i < NCOMMIT; i++) begin
                lane_pc = cif.commit_pc[i*XLEN +: XLEN];
                if (cif.commit_valid[i] && !trap_hit) begin
                    n_cnt           = n_cnt + CW'(1);
                    trace_d[wptr_d] = lane_pc;
                    wptr_d          = wptr_d + IW'(1);
                    if (cif.commit_instr[i*XLEN +: XLEN] == TRAP_INSN) begin
                        trap_hit  = 1'b1;
                        trap_pc_d = lane_pc;
                    end
                end
            end

            instret_d = instret_q + CNT_W'(n_cnt);
            if (32'(tcount_q) + 32'(n_cnt) >= 32'(TRACE_DEPTH)) begin
                tcount_d = TCW'(TRACE_DEPTH);
            end else begin
                tcount_d = tcount_q + TCW'(n_cnt);
            end
            stall_d = any_valid ? '0 : stall_q + SW'(1);

            if (trap_hit) begin
                state_d = S_DONE;
                if (cif.a0_value == '0) begin
                    status_d = ST_GOOD;
                end else if (cif.a0_value == XLEN'(1)) begin
                    status_d = ST_BAD;
                end else begin
                    status_d = ST_UNKNOWN;
                end
            end else if (cycle_d == CNT_W'(MAX_CYCLES)) begin
                state_d  = S_DONE;
                status_d = ST_TIMEOUT;
            end else if (!any_valid && stall_d == SW'(STALL_LIMIT)) begin
                state_d  = S_DONE;
                status_d = ST_STALL;
            end
        end
    end

    assign rd_ptr        = wptr_q - IW'(1) - trace_rd_idx_i;
    assign trace_rd_pc_o = ({1'b0, trace_rd_idx_i} < tcount_q) ? trace_q[rd_ptr] : '0;
    assign trace_count_o = tcount_q;
    assign done_o        = (state_q == S_DONE);
    assign status_o      = status_q;
    assign cycle_count_o = cycle_q;
    assign instret_o     = instret_q;
    assign trap_pc_o     = trap_pc_q;
endmodule

// File: tb/tb_sim_trap_monitor.sv
// tb/tb_sim_trap_monitor.sv - randomized scoreboard bench for sim_trap_monitor
module tb_sim_trap_monitor;
    localparam int          NC   = 4;
    localparam int          MAXC = 40;
    localparam int          STL  = 8;
    localparam int          DEP  = 4;
    localparam logic [31:0] TRAP = 32'h00100073;

    typedef struct packed {
        logic [2:0]            status;
        logic [63:0]           cyc;
        logic [63:0]           inst;
        logic [31:0]           tpc;
        logic [2:0]            tcount;
        logic [DEP-1:0][31:0]  tr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sim_trap_monitor_if #(.XLEN(32), .NCOMMIT(NC)) cif ();
    sim_trap_monitor_if #(.XLEN(32), .NCOMMIT(1))  cif2 ();

    logic [1:0]  rd_idx = '0;
    logic [31:0] rd_pc;
    logic [2:0]  tcnt;
    logic        done;
    logic [2:0]  status;
    logic [63:0] cyc, inst;
    logic [31:0] tpc;

    logic        co_idx = 1'b0;
    logic [31:0] co_rd_pc;
    logic [1:0]  co_tcnt;
    logic        co_done;
    logic [2:0]  co_status;
    logic [63:0] co_cyc, co_inst;
    logic [31:0] co_tpc;

    sim_trap_monitor #(.XLEN(32), .NCOMMIT(NC), .MAX_CYCLES(MAXC), .STALL_LIMIT(STL),
                       .TRACE_DEPTH(DEP), .TRAP_INSN(TRAP), .CNT_W(64)) u_dut (
        .clk(clk), .rst(rst), .cif(cif),
        .trace_rd_idx_i(rd_idx), .trace_rd_pc_o(rd_pc), .trace_count_o(tcnt),
        .done_o(done), .status_o(status), .cycle_count_o(cyc), .instret_o(inst), .trap_pc_o(tpc)
    );

    // Cycle and stall limits coincide here; TIMEOUT must win.
    sim_trap_monitor #(.XLEN(32), .NCOMMIT(1), .MAX_CYCLES(8), .STALL_LIMIT(8),
                       .TRACE_DEPTH(2), .TRAP_INSN(TRAP), .CNT_W(64)) u_co (
        .clk(clk), .rst(rst), .cif(cif2),
        .trace_rd_idx_i(co_idx), .trace_rd_pc_o(co_rd_pc), .trace_count_o(co_tcnt),
        .done_o(co_done), .status_o(co_status), .cycle_count_o(co_cyc), .instret_o(co_inst), .trap_pc_o(co_tpc)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   checked = 0;
    exp_t exp_q[$];

    int          m_cyc, m_inst, m_stall;
    bit          m_done;
    logic [31:0] m_tpc;
    logic [2:0]  m_status;
    logic [31:0] m_tr[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_inst = 0; m_stall = 0; m_done = 0;
        m_tpc = '0; m_status = 3'd0;
        m_tr.delete();
    endtask

    task automatic model_step(input logic [NC-1:0] v, input logic [NC*32-1:0] pcs,
                              input logic [NC*32-1:0] ins, input logic [31:0] a0);
        bit   trap = 0;
        int   n = 0;
        exp_t e;
        m_cyc++;
        for (int i = 0; i < NC; i++) begin
            if (v[i] && !trap) begin
                n++;
                m_tr.push_back(pcs[i*32 +: 32]);
                if (m_tr.size() > DEP) void'(m_tr.pop_front());
                if (ins[i*32 +: 32] == TRAP) begin
                    trap  = 1;
                    m_tpc = pcs[i*32 +: 32];
                end
            end
        end
        m_inst += n;
        m_stall = (v != '0) ? 0 : m_stall + 1;
        if (trap)                              m_status = (a0 == 0) ? 3'd1 : (a0 == 1) ? 3'd2 : 3'd3;
        else if (m_cyc == MAXC)                m_status = 3'd4;
        else if (v == '0 && m_stall == STL)    m_status = 3'd5;
        if (m_status != 3'd0) begin
            m_done   = 1;
            e.status = m_status;
            e.cyc    = 64'(m_cyc);
            e.inst   = 64'(m_inst);
            e.tpc    = m_tpc;
            e.tcount = 3'(m_tr.size());
            for (int i = 0; i < DEP; i++)
                e.tr[i] = (i < m_tr.size()) ? m_tr[m_tr.size()-1-i] : 32'h0;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_cycle(input logic [NC-1:0] v, input logic [NC*32-1:0] pcs,
                               input logic [NC*32-1:0] ins, input logic [31:0] a0);
        cif.commit_valid = v;
        cif.commit_pc    = pcs;
        cif.commit_instr = ins;
        cif.a0_value     = a0;
        if (!m_done) model_step(v, pcs, ins, a0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cif.commit_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("rst_done", 64'(done), 64'd0);
        check("rst_status", 64'(status), 64'd0);
        check("rst_cycles", cyc, 64'd0);
        check("rst_instret", inst, 64'd0);
        check("rst_trap_pc", 64'(tpc), 64'd0);
        check("rst_trace_count", 64'(tcnt), 64'd0);
    endtask

    task automatic rand_cycle(input int mode);
        logic [NC-1:0]    v;
        logic [NC*32-1:0] pcs, ins;
        logic [31:0]      a0;
        int               r;
        for (int i = 0; i < NC; i++) begin
            r          = int'($urandom_range(99));
            v[i]       = (mode == 0) ? (r < 75) : (mode == 1) ? (r < 60) : (r < 3);
            pcs[i*32 +: 32] = $urandom() & 32'hFFFF_FFFC;
            ins[i*32 +: 32] = (mode == 0 && $urandom_range(9) == 0) ? TRAP : ($urandom() | 32'h3);
            if (ins[i*32 +: 32] == TRAP && mode != 0) ins[i*32 +: 32] = 32'h13;
        end
        r  = int'($urandom_range(2));
        a0 = (r == 0) ? 32'd0 : (r == 1) ? 32'd1 : ($urandom() | 32'h2);
        drive_cycle(v, pcs, ins, a0);
    endtask

    task automatic finish_test();
        int c0 = checked - 1;
        int k  = 0;
        for (int j = 0; j < 3; j++) rand_cycle(0);
        while (checked == c0 + 1 && exp_q.size() != 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("result_seen", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        do_reset();
    endtask

    // Monitor: compares a popped expectation each time done rises, after a few frozen cycles.
    initial begin
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (done && !prev) begin
                    if (exp_q.size() == 0) begin
                        check("done_unexpected", 64'(done), 64'd0);
                    end else begin
                        e = exp_q[0];
                        repeat (2) @(negedge clk);
                        check("status", 64'(status), 64'(e.status));
                        check("cycle_count", cyc, e.cyc);
                        check("instret", inst, e.inst);
                        check("trap_pc", 64'(tpc), 64'(e.tpc));
                        check("trace_count", 64'(tcnt), 64'(e.tcount));
                        for (int i = 0; i < DEP; i++) begin
                            rd_idx = 2'(i);
                            #1;
                            check($sformatf("trace_idx%0d", i), 64'(rd_pc), 64'(e.tr[i]));
                        end
                        check("done_sticky", 64'(done), 64'd1);
                        void'(exp_q.pop_front());
                        checked++;
                    end
                end
                prev = done;
            end
        end
    end

    initial begin
        logic [NC*32-1:0] pcs, ins;
        cif.commit_valid  = '0; cif.commit_pc  = '0; cif.commit_instr  = '0; cif.a0_value  = '0;
        cif2.commit_valid = '0; cif2.commit_pc = '0; cif2.commit_instr = '0; cif2.a0_value = '0;
        @(posedge clk); #1;
        do_reset();

        // Idle from reset: main instance stalls at 8, coincident instance times out at 8.
        for (int c = 0; c < STL; c++) drive_cycle('0, '0, '0, '0);
        check("co_done", 64'(co_done), 64'd1);
        check("co_status", 64'(co_status), 64'd4);
        check("co_cycles", co_cyc, 64'd8);
        finish_test();

        // Five commits then a good trap on lane 0.
        for (int c = 0; c < 5; c++) drive_cycle(4'b0001, 128'(32'h8000_0000 + 32'(4*c)), 128'h13, '0);
        drive_cycle(4'b0001, 128'h8000_0014, 128'(TRAP), 32'd0);
        finish_test();

        // All lanes valid, trap on lane 1 with a0=1; lanes 2-3 must be dropped.
        pcs = {32'h3000_000c, 32'h3000_0008, 32'h3000_0004, 32'h3000_0000};
        drive_cycle(4'b1111, pcs, {4{32'h13}}, 32'd0);
        pcs = {32'h4000_000c, 32'h4000_0008, 32'h4000_0004, 32'h4000_0000};
        ins = {32'h13, TRAP, TRAP, 32'h13};
        drive_cycle(4'b1111, pcs, ins, 32'd1);
        finish_test();

        // Non-contiguous valid with a trap on lane 3 and an unknown exit code.
        pcs = {32'h5000_000c, 32'h5000_0008, 32'h5000_0004, 32'h5000_0000};
        ins = {TRAP, 32'h13, TRAP, 32'h13};
        drive_cycle(4'b1001, pcs, ins, 32'h2a);
        finish_test();

        // Trace wrap: six commits 0x0..0x14 then idle into STALL.
        for (int c = 0; c < 6; c++) drive_cycle(4'b0001, 128'(4*c), 128'h13, '0);
        while (!m_done) drive_cycle('0, '0, '0, '0);
        finish_test();

        for (int t = 0; t < 40; t++) begin
            int mode = t % 3;
            while (!m_done) rand_cycle(mode);
            finish_test();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
